// File: rtl/eth_tx_framer.sv
// Byte-serial Ethernet TX framer: preamble/SFD, zero pad to MIN_LEN, CRC-32 FCS, inter-frame gap.
// Output registers are loaded from the next-state decision, so txd/tx_en describe the cycle after the decision.
module eth_tx_framer #(
    parameter int PREAMBLE_LEN = 7,
    parameter int MIN_LEN      = 60,
    parameter int IFG_CYCLES   = 12
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] s_axis_tdata,
    input  logic       s_axis_tvalid,
    input  logic       s_axis_tlast,
    output logic       s_axis_tready,
    output logic [7:0] gmii_txd,
    output logic       gmii_tx_en,
    output logic       gmii_tx_er,
    output logic       frame_done_o,
    output logic       underflow_o
);

    localparam int                CNT_W   = 16;
    localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0]  PRE_N   = CNT_W'(PREAMBLE_LEN);
    localparam logic [CNT_W-1:0]  IFG_N   = CNT_W'(IFG_CYCLES);
    localparam logic [CNT_W-1:0]  FCS_END = CNT_W'(4);
    localparam logic [10:0]       MIN_N   = 11'(MIN_LEN);
    localparam bit                NO_PRE  = (PREAMBLE_LEN == 0);
    localparam bit                NO_IFG  = (IFG_CYCLES == 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREAMBLE,
        S_SFD,
        S_DATA,
        S_PAD,
        S_FCS,
        S_DRAIN,
        S_IFG
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [31:0]      r_crc;
    logic [10:0]      r_len;
    logic [7:0]       r_txd;
    logic             r_tx_en;
    logic             r_tx_er;
    logic             r_done;
    logic             r_underflow;

    state_t           w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [31:0]      w_crc_nxt;
    logic [10:0]      w_len_nxt;
    logic [7:0]       w_txd_nxt;
    logic             w_tx_en_nxt;
    logic             w_tx_er_nxt;
    logic             w_done_nxt;
    logic             w_underflow_nxt;

    logic [10:0]      w_len_inc;
    logic [31:0]      w_crc_data;
    logic [31:0]      w_crc_pad;
    logic [31:0]      w_fcs;

    // Reflected IEEE 802.3 CRC, one byte per call, LSB first.
    function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc ^ {24'h0, data};
        for (int k = 0; k < 8; k++) begin
            c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return c;
    endfunction

    assign w_len_inc  = (r_len == 11'h7FF) ? r_len : r_len + 11'd1;
    assign w_crc_data = crc_byte(r_crc, s_axis_tdata);
    assign w_crc_pad  = crc_byte(r_crc, 8'h00);
    assign w_fcs      = ~r_crc;

    assign s_axis_tready = (r_state == S_SFD) || (r_state == S_DATA) || (r_state == S_DRAIN);

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_crc_nxt       = r_crc;
        w_len_nxt       = r_len;
        w_txd_nxt       = 8'h00;
        w_tx_en_nxt     = 1'b0;
        w_tx_er_nxt     = 1'b0;
        w_done_nxt      = 1'b0;
        w_underflow_nxt = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_crc_nxt = 32'hFFFF_FFFF;
                w_len_nxt = 11'd0;
                if (s_axis_tvalid) begin
                    w_tx_en_nxt = 1'b1;
                    if (NO_PRE) begin
                        w_txd_nxt   = 8'hD5;
                        w_state_nxt = S_SFD;
                    end else begin
                        w_txd_nxt   = 8'h55;
                        w_cnt_nxt   = CNT_ONE;
                        w_state_nxt = S_PREAMBLE;
                    end
                end
            end

            S_PREAMBLE: begin
                w_tx_en_nxt = 1'b1;
                if (r_cnt >= PRE_N) begin
                    w_txd_nxt   = 8'hD5;
                    w_state_nxt = S_SFD;
                end else begin
                    w_txd_nxt = 8'h55;
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end

            S_SFD, S_DATA: begin
                w_tx_en_nxt = 1'b1;
                if (s_axis_tvalid) begin
                    w_txd_nxt   = s_axis_tdata;
                    w_crc_nxt   = w_crc_data;
                    w_len_nxt   = w_len_inc;
                    w_state_nxt = S_DATA;
                    if (s_axis_tlast) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = (w_len_inc < MIN_N) ? S_PAD : S_FCS;
                    end
                end else begin
                    // Starved mid-frame: poison the frame on the wire and discard the rest.
                    w_tx_er_nxt     = 1'b1;
                    w_underflow_nxt = 1'b1;
                    w_state_nxt     = S_DRAIN;
                end
            end

            S_PAD: begin
                w_tx_en_nxt = 1'b1;
                w_crc_nxt   = w_crc_pad;
                w_len_nxt   = w_len_inc;
                if (w_len_inc >= MIN_N) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_FCS;
                end
            end

            S_FCS: begin
                if (r_cnt == FCS_END) begin
                    w_cnt_nxt   = IFG_N;
                    w_state_nxt = NO_IFG ? S_IDLE : S_IFG;
                end else begin
                    w_tx_en_nxt = 1'b1;
                    w_cnt_nxt   = r_cnt + CNT_ONE;
                    case (r_cnt[1:0])
                        2'd0:    w_txd_nxt = w_fcs[7:0];
                        2'd1:    w_txd_nxt = w_fcs[15:8];
                        2'd2:    w_txd_nxt = w_fcs[23:16];
                        default: begin
                            w_txd_nxt  = w_fcs[31:24];
                            w_done_nxt = 1'b1;
                        end
                    endcase
                end
            end

            S_DRAIN: begin
                if (s_axis_tvalid && s_axis_tlast) begin
                    w_cnt_nxt   = IFG_N;
                    w_state_nxt = NO_IFG ? S_IDLE : S_IFG;
                end
            end

            S_IFG: begin
                if (r_cnt <= CNT_ONE) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_ONE;
                end
            end

            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_crc       <= 32'hFFFF_FFFF;
            r_len       <= 11'd0;
            r_txd       <= 8'h00;
            r_tx_en     <= 1'b0;
            r_tx_er     <= 1'b0;
            r_done      <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_crc       <= w_crc_nxt;
            r_len       <= w_len_nxt;
            r_txd       <= w_txd_nxt;
            r_tx_en     <= w_tx_en_nxt;
            r_tx_er     <= w_tx_er_nxt;
            r_done      <= w_done_nxt;
            r_underflow <= w_underflow_nxt;
        end
    end

    assign gmii_txd     = r_txd;
    assign gmii_tx_en   = r_tx_en;
    assign gmii_tx_er   = r_tx_er;
    assign frame_done_o = r_done;
    assign underflow_o  = r_underflow;

endmodule

// File: doc/eth_tx_framer.md
# eth_tx_framer

Byte-serial Ethernet transmit framer between the TX frame buffer read-out and the RGMII transmit path of `eth_rgmii`. It consumes one frame as an 8-bit AXI-Stream (destination MAC through last payload byte). It emits a GMII-style byte stream with:
- preamble and SFD prepended,
- zero padding to the minimum frame size,
- CRC-32 FCS appended,
- enforced inter-frame gap.

## Interface
Parameters:
- `PREAMBLE_LEN`, 7: number of 0x55 bytes before the SFD.
- `MIN_LEN`, 60: minimum bytes before FCS; shorter frames are zero-padded. 0 disables padding.
- `IFG_CYCLES`, 12: idle cycles forced after each frame.

Ports:
- `clk_i` in 1: single clock (125 MHz byte clock); all logic on its rising edge.
- `rst_i` in 1: reset, asynchronous assert, active-high.
- `s_axis_tdata` in 8: frame byte.
- `s_axis_tvalid` in 1: byte valid.
- `s_axis_tlast` in 1: last byte of frame.
- `s_axis_tready` out 1: byte accepted when `tvalid && tready`.
- `gmii_txd` out 8: transmit byte, registered.
- `gmii_tx_en` out 1: transmit enable, registered.
- `gmii_tx_er` out 1: transmit error, registered.
- `frame_done_o` out 1: one-cycle pulse, frame with good FCS completed.
- `underflow_o` out 1: one-cycle pulse, frame aborted on input starvation.

## Operation
- Reset values: `gmii_txd`=0x00, `gmii_tx_en`=0, `gmii_tx_er`=0, `s_axis_tready`=0, `frame_done_o`=0, `underflow_o`=0, state IDLE, CRC=0xFFFFFFFF, byte counter 0.
- States: IDLE, PREAMBLE, SFD, DATA, PAD, FCS, DRAIN, IFG.
- IDLE:
  - `tready`=0.
  - `tvalid`=1 → PREAMBLE.
  - Data is not consumed here.
- PREAMBLE: `PREAMBLE_LEN` cycles of txd=0x55, tx_en=1, then SFD.
- SFD:
  - One cycle of txd=0xD5.
  - `tready`=1 during this cycle, so byte 0 follows with no bubble.
- DATA:
  - `tready`=1; each accepted byte is registered onto txd, tx_en=1.
  - CRC and byte counter update on each accepted byte.
  - On `tlast` accepted: count < `MIN_LEN` → PAD, else → FCS.
- PAD: txd=0x00, CRC updated with 0x00, until count reaches `MIN_LEN`, then FCS.
- FCS:
  - 4 cycles driving `~crc`, least-significant byte first.
  - `frame_done_o` pulses in the cycle the 4th FCS byte is registered onto txd.
  - Then → IFG.
- CRC rules:
  - Reflected IEEE 802.3 polynomial 0xEDB88320, byte-wise, LSB first.
  - Init 0xFFFFFFFF at frame start.
  - Covers data and pad bytes, never preamble or SFD.
- Underflow: in DATA, `tready`=1 with `tvalid`=0 → abort:
  - txd=0x00, tx_en=1, tx_er=1 for exactly one cycle;
  - `underflow_o` pulses;
  - → DRAIN.
- DRAIN: tx_en=0, `tready`=1, input bytes discarded until `tlast` accepted, then → IFG.
- IFG: tx_en=0, `tready`=0 for `IFG_CYCLES` cycles, then → IDLE.
- Byte counter is 11 bits, saturating at 2047. No maximum-length enforcement.
- Reset mid-frame: all outputs take their reset values immediately. The partial frame is lost; there is no FCS and no `frame_done_o`.

## Timing
- `tvalid` first seen high in IDLE at cycle 0:
  - txd=0x55 on cycles 1..`PREAMBLE_LEN`;
  - 0xD5 on cycle `PREAMBLE_LEN`+1;
  - data byte i on cycle `PREAMBLE_LEN`+2+i.
- Frame of L data bytes, P = max(L, `MIN_LEN`): tx_en high for `PREAMBLE_LEN`+1+P+4 consecutive cycles.
- tx_en low for at least `IFG_CYCLES` cycles between frames. Back-to-back `tvalid` gives exactly `IFG_CYCLES`+1 low cycles: IFG plus one IDLE.
- `tready` is a function of state only, never of `tvalid`.
- tx_er is high only during the single abort cycle.

## Test plan
- `MIN_LEN`=0, ASCII "123456789" (9 bytes, continuous `tvalid`) → txd = 7×0x55, 0xD5, 0x31..0x39, then 0x26, 0x39, 0xF4, 0xCB; tx_en high 21 cycles; `frame_done_o` pulses once.
- Default parameters, 14-byte header 0x10 0x32 0x00 0x98 0x70 0x20 0x32 0x10 0x02 0x07 0x89 0x00 0x2E 0x00 → 46 0x00 pad bytes after byte 13; tx_en high 72 cycles; FCS matches software CRC over 60 bytes.
- Two 64-byte frames back-to-back with `tvalid` held high → tx_en low exactly 13 cycles between frames; both FCS correct.
- `tvalid` dropped for one cycle after byte 20 of a 100-byte frame → tx_er=1 with tx_en=1 for one cycle, `underflow_o` pulse, remaining 79 bytes drained, no `frame_done_o`, 12-cycle gap, next frame transmits correctly.
- `rst_i` asserted during PAD → tx_en=0, `tready`=0 immediately after assertion; after release a new frame transmits with a correct FCS (CRC reinitialised).
- `tlast` on byte 0 (L=1) → one data byte, 59 pad bytes, 4 FCS bytes; tx_en high 72 cycles.
